// File: rtl/vcve2_pkg.sv
// Shared types for the instruction aligner: FSM states and the 32-bit opcode marker.
package vcve2_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_SKIP  = 2'd2,
        S_ERR   = 2'd3
    } aligner_state_e;

    localparam logic [1:0] INSTR_32B = 2'b11;

    // A halfword starts a compressed instruction unless its low opcode bits are 2'b11.
    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != INSTR_32B;
    endfunction

endpackage

// File: rtl/cve2_instr_aligner.sv
// Aligns 32-bit fetch words into whole 16/32-bit instructions at halfword granularity.
// Define CVE2_ALIGNER_OUT_REG_EN to add a single-entry registered output stage.
module cve2_instr_aligner
    import vcve2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_err_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_err_o
);

    aligner_state_e r_state;
    logic [15:0]    r_res;
    logic [31:0]    r_res_addr;
    logic           r_res_err;
    logic [31:0]    r_err_instr;
    logic [31:0]    r_err_addr;

    logic        w_core_valid;
    logic [31:0] w_core_instr;
    logic [31:0] w_core_addr;
    logic        w_core_err;
    logic        w_uses_fetch;
    logic        w_skip;
    logic        w_sink_ready;
    logic        w_accept;
    logic        w_fetch_ready;
    logic [31:0] w_fetch_addr_nxt;
    logic        w_unused_flush_addr;

    // Only bit 1 of the restart PC matters; the word address arrives with the fetch data.
    assign w_unused_flush_addr = ^{flush_addr_i[31:2], flush_addr_i[0]};
    assign w_fetch_addr_nxt    = fetch_addr_i + 32'd2;

    // Candidate instruction from residue and/or the current fetch word.
    always_comb begin
        w_core_valid = 1'b0;
        w_core_instr = '0;
        w_core_addr  = '0;
        w_core_err   = 1'b0;
        w_uses_fetch = 1'b0;
        w_skip       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (fetch_valid_i) begin
                    w_core_valid = 1'b1;
                    w_core_addr  = fetch_addr_i;
                    w_core_err   = fetch_err_i;
                    w_uses_fetch = 1'b1;
                    w_core_instr = is_compressed(fetch_rdata_i[1:0]) ?
                                   {16'h0000, fetch_rdata_i[15:0]} : fetch_rdata_i;
                end
            end
            S_HALF: begin
                w_core_addr = r_res_addr;
                if (is_compressed(r_res[1:0])) begin
                    w_core_valid = 1'b1;
                    w_core_instr = {16'h0000, r_res};
                    w_core_err   = r_res_err;
                end else if (fetch_valid_i) begin
                    w_core_valid = 1'b1;
                    w_core_instr = {fetch_rdata_i[15:0], r_res};
                    w_core_err   = r_res_err | fetch_err_i;
                    w_uses_fetch = 1'b1;
                end
            end
            S_SKIP: begin
                w_skip = fetch_valid_i;
            end
            S_ERR: begin
                w_core_valid = 1'b1;
                w_core_instr = r_err_instr;
                w_core_addr  = r_err_addr;
                w_core_err   = 1'b1;
            end
            default: begin
                w_core_valid = 1'b0;
            end
        endcase
        if (flush_i) begin
            w_core_valid = 1'b0;
            w_skip       = 1'b0;
        end
    end

    assign w_accept      = w_core_valid & w_sink_ready;
    assign w_fetch_ready = (w_accept & w_uses_fetch) | w_skip;
    assign fetch_ready_o = w_fetch_ready & ~rst_i;

    // State and residue; the skipped word's error travels with its upper halfword.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_EMPTY;
            r_res       <= '0;
            r_res_addr  <= '0;
            r_res_err   <= 1'b0;
            r_err_instr <= '0;
            r_err_addr  <= '0;
        end else if (flush_i) begin
            r_state    <= flush_addr_i[1] ? S_SKIP : S_EMPTY;
            r_res      <= '0;
            r_res_addr <= '0;
            r_res_err  <= 1'b0;
        end else if (w_skip) begin
            r_res      <= fetch_rdata_i[31:16];
            r_res_addr <= w_fetch_addr_nxt;
            r_res_err  <= fetch_err_i;
            r_state    <= S_HALF;
        end else if (w_accept) begin
            if (w_core_err) begin
                r_state     <= S_ERR;
                r_err_instr <= w_core_instr;
                r_err_addr  <= w_core_addr;
            end else if (w_uses_fetch &&
                         (r_state == S_HALF || is_compressed(fetch_rdata_i[1:0]))) begin
                r_res      <= fetch_rdata_i[31:16];
                r_res_addr <= w_fetch_addr_nxt;
                r_res_err  <= 1'b0;
                r_state    <= S_HALF;
            end else if (r_state == S_HALF) begin
                r_state <= S_EMPTY;
            end
        end
    end

`ifdef CVE2_ALIGNER_OUT_REG_EN
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_addr;
    logic        r_out_err;

    assign w_sink_ready = ~r_out_valid | instr_ready_i;

    // Single-entry output stage, refilled whenever it is empty or being drained.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= '0;
            r_out_err   <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_sink_ready) begin
            r_out_valid <= w_core_valid;
            r_out_instr <= w_core_instr;
            r_out_addr  <= w_core_addr;
            r_out_err   <= w_core_err;
        end
    end

    assign instr_valid_o = r_out_valid & ~flush_i;
    assign instr_o       = r_out_instr;
    assign instr_addr_o  = r_out_addr;
    assign instr_err_o   = r_out_err;
`else
    assign w_sink_ready  = instr_ready_i;
    assign instr_valid_o = w_core_valid & ~rst_i;
    assign instr_o       = rst_i ? 32'h0 : w_core_instr;
    assign instr_addr_o  = rst_i ? 32'h0 : w_core_addr;
    assign instr_err_o   = w_core_err & ~rst_i;
`endif

endmodule

// File: tb/tb_cve2_instr_aligner.sv
// Self-checking bench for cve2_instr_aligner: vector table, hand sequences, random streams vs model.
module tb_cve2_instr_aligner;

`ifdef CVE2_ALIGNER_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_err_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_err_o;

    cve2_instr_aligner dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_rdata_i (fetch_rdata_i),
        .fetch_addr_i  (fetch_addr_i),
        .fetch_err_i   (fetch_err_i),
        .fetch_ready_o (fetch_ready_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .instr_err_o   (instr_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } ins_t;

    typedef struct packed {
        logic [31:0]       start;
        logic [1:0]        nw;
        logic [2:0][31:0]  w;
        logic [2:0]        e;
        logic [1:0]        nx;
        ins_t [2:0]        x;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] q_word [$];
    logic [31:0] q_addr [$];
    logic        q_err  [$];
    ins_t        exp_q  [$];

    int          total = 0;
    int          bad   = 0;
    int          ngot;
    bit          presented;
    bit          allow_extra;
    logic        p_valid, p_ready, p_err;
    logic [31:0] p_instr, p_addr;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] i, input logic [31:0] a, input logic e);
        ins_t t;
        t.instr = i;
        t.addr  = a;
        t.err   = e;
        return t;
    endfunction

    task automatic set_vec(input int i, input logic [31:0] st, input logic [1:0] nw,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [2:0] e, input logic [1:0] nx,
                           input ins_t x0, input ins_t x1, input ins_t x2);
        tbl[i].start = st;
        tbl[i].nw    = nw;
        tbl[i].w[0]  = w0;
        tbl[i].w[1]  = w1;
        tbl[i].w[2]  = w2;
        tbl[i].e     = e;
        tbl[i].nx    = nx;
        tbl[i].x[0]  = x0;
        tbl[i].x[1]  = x1;
        tbl[i].x[2]  = x2;
    endtask

    task automatic clear_stream();
        q_word.delete();
        q_addr.delete();
        q_err.delete();
        exp_q.delete();
        presented = 1'b0;
    endtask

    // Reference: split the word stream into halfwords and walk it by the RISC-V length rule.
    task automatic model_build(input logic [31:0] start);
        logic [15:0] hw [$];
        logic [31:0] ha [$];
        logic        he [$];
        int          i;
        ins_t        t;
        exp_q.delete();
        for (int k = 0; k < q_word.size(); k++) begin
            hw.push_back(q_word[k][15:0]);
            ha.push_back(q_addr[k]);
            he.push_back(q_err[k]);
            hw.push_back(q_word[k][31:16]);
            ha.push_back(q_addr[k] + 32'd2);
            he.push_back(q_err[k]);
        end
        i = start[1] ? 1 : 0;
        while (i < hw.size()) begin
            if (hw[i][1:0] != 2'b11) begin
                t = mk({16'h0, hw[i]}, ha[i], he[i]);
                i = i + 1;
            end else if (i + 1 < hw.size()) begin
                t = mk({hw[i+1], hw[i]}, ha[i], he[i] | he[i+1]);
                i = i + 2;
            end else begin
                break;
            end
            exp_q.push_back(t);
            if (t.err) break;
        end
    endtask

    task automatic drive_fetch(input int gap_pct);
        if (q_word.size() > 0 && (presented || $urandom_range(99) >= gap_pct)) begin
            presented     = 1'b1;
            fetch_valid_i = 1'b1;
            fetch_rdata_i = q_word[0];
            fetch_addr_i  = q_addr[0];
            fetch_err_i   = q_err[0];
        end else begin
            fetch_valid_i = 1'b0;
            fetch_rdata_i = $urandom;
            fetch_addr_i  = $urandom;
            fetch_err_i   = 1'b0;
        end
    endtask

    task automatic sample_and_check();
        if (p_valid && !p_ready)
            chk("hold", 96'({instr_valid_o, instr_o, instr_addr_o, instr_err_o}),
                96'({1'b1, p_instr, p_addr, p_err}));
        if (instr_valid_o && instr_ready_i) begin
            if (ngot < exp_q.size())
                chk("instr", 96'({instr_o, instr_addr_o, instr_err_o}), 96'(exp_q[ngot]));
            else if (!allow_extra)
                chk("extra_instr", 96'(ngot), 96'(exp_q.size()));
            ngot++;
        end
        if (fetch_ready_o) begin
            chk("fready_needs_valid", 96'(fetch_valid_i), 96'(1));
            if (fetch_valid_i && q_word.size() > 0) begin
                void'(q_word.pop_front());
                void'(q_addr.pop_front());
                void'(q_err.pop_front());
            end
            presented = 1'b0;
        end
        p_valid = instr_valid_o;
        p_ready = instr_ready_i;
        p_instr = instr_o;
        p_addr  = instr_addr_o;
        p_err   = instr_err_o;
    endtask

    task automatic cycle(input int rdy_pct, input int gap_pct);
        @(posedge clk_i);
        #1;
        flush_i       = 1'b0;
        instr_ready_i = ($urandom_range(99) < rdy_pct);
        drive_fetch(gap_pct);
        @(negedge clk_i);
        sample_and_check();
    endtask

    task automatic do_flush(input logic [31:0] start);
        @(posedge clk_i);
        #1;
        flush_i       = 1'b1;
        flush_addr_i  = start;
        instr_ready_i = 1'b1;
        drive_fetch(0);
        @(negedge clk_i);
        chk("flush_quiet", 96'({instr_valid_o, fetch_ready_o}), 96'(0));
        p_valid = 1'b0;
        ngot    = 0;
    endtask

    // Collect the expected instructions, then check idle/drained or held error.
    task automatic run_body(input int rdy, input int gap);
        int  cyc;
        bit  erred;
        cyc = 0;
        while (ngot < exp_q.size() && cyc < 300) begin
            cycle(rdy, gap);
            cyc++;
        end
        chk("instr_count", 96'(ngot), 96'(exp_q.size()));
        erred = (exp_q.size() > 0) && exp_q[exp_q.size()-1].err;
        allow_extra = erred;
        for (int k = 0; k < 4; k++) begin
            cycle(erred ? rdy : 100, 0);
            if (erred)
                chk("err_hold", 96'({instr_valid_o, instr_err_o, fetch_ready_o}), 96'(3'b110));
            else
                chk("idle", 96'(instr_valid_o), 96'(0));
        end
        if (!erred) chk("drained", 96'(q_word.size()), 96'(0));
        allow_extra = 1'b0;
    endtask

    task automatic run_vec(input int i, input int rdy, input int gap);
        logic [31:0] base;
        clear_stream();
        base = tbl[i].start & 32'hFFFF_FFFC;
        for (int k = 0; k < int'(tbl[i].nw); k++) begin
            q_word.push_back(tbl[i].w[k]);
            q_addr.push_back(base + 32'(4 * k));
            q_err.push_back(tbl[i].e[k]);
        end
        for (int k = 0; k < int'(tbl[i].nx); k++) exp_q.push_back(tbl[i].x[k]);
        do_flush(tbl[i].start);
        run_body(rdy, gap);
    endtask

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        flush_addr_i  = '0;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = '0;
        fetch_addr_i  = '0;
        fetch_err_i   = 1'b0;
        instr_ready_i = 1'b0;
        allow_extra   = 1'b0;
        p_valid       = 1'b0;
        ngot          = 0;
        #2;
        chk("reset_out", 96'({instr_valid_o, instr_o, instr_addr_o, instr_err_o, fetch_ready_o}), 96'(0));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        set_vec(0, 32'h0, 2'd2, 32'h0000_0013, 32'h0010_0093, 32'h0, 3'b000, 2'd2,
                mk(32'h0000_0013, 32'h0, 0), mk(32'h0010_0093, 32'h4, 0), mk(0, 0, 0));
        set_vec(1, 32'h0, 2'd1, 32'h4505_4501, 32'h0, 32'h0, 3'b000, 2'd2,
                mk(32'h0000_4501, 32'h0, 0), mk(32'h0000_4505, 32'h2, 0), mk(0, 0, 0));
        set_vec(2, 32'h0, 2'd2, 32'h0093_4501, 32'h0000_0010, 32'h0, 3'b000, 2'd3,
                mk(32'h0000_4501, 32'h0, 0), mk(32'h0010_0093, 32'h2, 0), mk(32'h0, 32'h6, 0));
        set_vec(3, 32'h102, 2'd2, 32'h0093_1117, 32'h0000_0010, 32'h0, 3'b000, 2'd2,
                mk(32'h0010_0093, 32'h102, 0), mk(32'h0, 32'h106, 0), mk(0, 0, 0));
        set_vec(4, 32'h0, 2'd3, 32'h0093_4501, 32'h0000_0010, 32'h0000_0013, 3'b010, 2'd2,
                mk(32'h0000_4501, 32'h0, 0), mk(32'h0010_0093, 32'h2, 1), mk(0, 0, 0));
        set_vec(5, 32'hFFFF_FFFC, 2'd2, 32'h0093_4501, 32'h0000_0010, 32'h0, 3'b000, 2'd3,
                mk(32'h0000_4501, 32'hFFFF_FFFC, 0), mk(32'h0010_0093, 32'hFFFF_FFFE, 0),
                mk(32'h0, 32'h2, 0));
        set_vec(6, 32'h2, 2'd1, 32'h4505_1234, 32'h0, 32'h0, 3'b000, 2'd1,
                mk(32'h0000_4505, 32'h2, 0), mk(0, 0, 0), mk(0, 0, 0));
        set_vec(7, 32'h0, 2'd1, 32'h0013_4501, 32'h0, 32'h0, 3'b000, 2'd1,
                mk(32'h0000_4501, 32'h0, 0), mk(0, 0, 0), mk(0, 0, 0));

        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++)
                run_vec(i, (r == 0) ? 100 : 60, (r == 0) ? 0 : 30);

        // Backpressure on a compressed pair: output held while instr_ready_i is low.
        clear_stream();
        q_word.push_back(32'h4505_4501); q_addr.push_back(32'h0); q_err.push_back(1'b0);
        exp_q.push_back(mk(32'h0000_4501, 32'h0, 0));
        exp_q.push_back(mk(32'h0000_4505, 32'h2, 0));
        do_flush(32'h0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i);
            #1;
            flush_i       = 1'b0;
            instr_ready_i = (k >= 3);
            drive_fetch(0);
            @(negedge clk_i);
            chk("bp_valid", 96'(instr_valid_o), 96'(k >= LAT && k <= 4));
            if (k >= LAT && k <= 4)
                chk("bp_instr", 96'({instr_o, instr_addr_o}),
                    (k <= 3) ? 96'({32'h0000_4501, 32'h0}) : 96'({32'h0000_4505, 32'h2}));
            if (k == 4) chk("bp_fready", 96'(fetch_ready_o), 96'(0));
            sample_and_check();
        end
        chk("bp_count", 96'(ngot), 96'(2));

        // Asynchronous reset in the middle of a straddling instruction.
        clear_stream();
        q_word.push_back(32'h0093_4501); q_addr.push_back(32'h0); q_err.push_back(1'b0);
        q_word.push_back(32'h0000_0010); q_addr.push_back(32'h4); q_err.push_back(1'b0);
        exp_q.push_back(mk(32'h0000_4501, 32'h0, 0));
        do_flush(32'h0);
        cycle(100, 0);
        cycle(0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async", 96'({instr_valid_o, instr_o, instr_addr_o, instr_err_o, fetch_ready_o}), 96'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_stream();
        p_valid = 1'b0;
        ngot    = 0;
        q_word.push_back(32'h0000_0013); q_addr.push_back(32'h40); q_err.push_back(1'b0);
        exp_q.push_back(mk(32'h0000_0013, 32'h40, 0));
        run_body(100, 0);

        // Random streams against the halfword-walk model.
        for (int r = 0; r < 40; r++) begin
            logic [31:0] base;
            logic [31:0] start;
            int          n;
            clear_stream();
            n     = $urandom_range(1, 8);
            base  = $urandom & 32'hFFFF_FFFC;
            start = base | {30'h0, 1'($urandom_range(1)), 1'b0};
            for (int k = 0; k < n; k++) begin
                q_word.push_back($urandom);
                q_addr.push_back(base + 32'(4 * k));
                q_err.push_back($urandom_range(99) < 4);
            end
            model_build(start);
            do_flush(start);
            run_body($urandom_range(30, 100), $urandom_range(0, 50));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
